dsky_keypad_scanner: RTL

- Scans a 4x5 active-low DSKY key matrix and debounces the result.
- Drives the AGC top level's keyboard inputs: the 5-bit keycode MKEY1..MKEY5 and the PROCEED discrete.
- Sits directly upstream of the board-level AGC wrapper and replaces hard-wired key inputs.
- Runs in the SIM_CLK domain; all outputs are registered.

---
 rtl/dsky_keypad_scanner_if.sv | 42 ++++
 rtl/dsky_keypad_scanner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dsky_keypad_scanner_if.sv
// Keypad matrix / AGC keyboard bundle for dsky_keypad_scanner.
//   ROW_n    : row drive, one-hot low
//   COL_n    : column sense, active low, asynchronous
//   MKEY     : debounced 5-bit keycode (MKEY[4]=MKEY5 .. MKEY[0]=MKEY1)
//   PROCEED  : debounced PRO key
//   SCAN_ERR : one-cycle pulse after a scan with two or more code keys
//   KEY_STRB : one-cycle pulse when MKEY loads a nonzero code (only with KEYPAD_STRB_EN)
// master = scanner side, slave = matrix/AGC side.
interface dsky_keypad_scanner_if;
  logic [3:0] ROW_n;
  logic [4:0] COL_n;
  logic [4:0] MKEY;
  logic       PROCEED;
  logic       SCAN_ERR;
`ifdef KEYPAD_STRB_EN
  logic       KEY_STRB;
`endif

  modport master (
    input  COL_n,
    output ROW_n,
    output MKEY,
    output PROCEED,
    output SCAN_ERR
`ifdef KEYPAD_STRB_EN
    ,
    output KEY_STRB
`endif
  );

  modport slave (
    output COL_n,
    input  ROW_n,
    input  MKEY,
    input  PROCEED,
    input  SCAN_ERR
`ifdef KEYPAD_STRB_EN
    ,
    input  KEY_STRB
`endif
  );
endinterface

// File: rtl/dsky_keypad_scanner.sv
// DSKY 4x5 keypad scanner with debounce, feeding the AGC MKEY1..5 / PROCEED inputs.
// Ports:
//   SIM_CLK   : clock
//   SIM_RST_n : asynchronous active-low reset, synchronous release
//   kp        : dsky_keypad_scanner_if.master (ROW_n, COL_n, MKEY, PROCEED, SCAN_ERR[, KEY_STRB])
// Parameters: SCAN_DIV (cycles per row, >= 4), DEBOUNCE_SCANS (stable scans, >= 1).
// Optional feature macro: KEYPAD_STRB_EN adds KEY_STRB.
module dsky_keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 12800,
  parameter int unsigned DEBOUNCE_SCANS = 20
) (
  input logic                   SIM_CLK,
  input logic                   SIM_RST_n,
  dsky_keypad_scanner_if.master kp
);

  localparam int unsigned DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam int unsigned NCODE   = 18;
  localparam int unsigned NKEY    = 19;
  localparam int unsigned PRO_IDX = 18;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]   DB_MAX     = CNT_W'(DEBOUNCE_SCANS);

  // Octal keycodes indexed by row*5+col; r3c3 is PRO and r3c4 is unused.
  localparam logic [4:0] KEY_CODE [NCODE] = '{
    5'o01, 5'o02, 5'o03, 5'o04, 5'o05,
    5'o06, 5'o07, 5'o10, 5'o11, 5'o20,
    5'o21, 5'o37, 5'o32, 5'o33, 5'o36,
    5'o34, 5'o22, 5'o31
  };

  typedef enum logic [1:0] {
    ROW0 = 2'd0,
    ROW1 = 2'd1,
    ROW2 = 2'd2,
    ROW3 = 2'd3
  } row_state_e;

  row_state_e         state_q, state_d;
  logic [3:0]         row_n_q, row_n_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [4:0]         col_s1_q, col_s1_d;
  logic [4:0]         col_s2_q, col_s2_d;
  logic [NKEY-1:0]    keys_q, keys_d;
  logic               eval_q, eval_d;
  logic [4:0]         cand_q, cand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         mkey_q, mkey_d;
  logic               pro_cand_q, pro_cand_d;
  logic [CNT_W-1:0]   pro_cnt_q, pro_cnt_d;
  logic               proceed_q, proceed_d;
  logic               scan_err_q, scan_err_d;
`ifdef KEYPAD_STRB_EN
  logic               key_strb_q, key_strb_d;
`endif

  logic               code_any;
  logic               code_multi;
  logic [4:0]         scan_code;

  // Next-state: synchronizer, row scan, scan evaluation and debounce.
  always_comb begin
    col_s1_d   = kp.COL_n;
    col_s2_d   = col_s1_q;
    state_d    = state_q;
    dwell_d    = dwell_q;
    keys_d     = keys_q;
    eval_d     = 1'b0;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    mkey_d     = mkey_q;
    pro_cand_d = pro_cand_q;
    pro_cnt_d  = pro_cnt_q;
    proceed_d  = proceed_q;
    scan_err_d = 1'b0;
    code_any   = 1'b0;
    code_multi = 1'b0;
    scan_code  = '0;

    // Row dwell; the last dwell cycle captures that row's synchronized columns.
    if (dwell_q == DWELL_LAST) begin
      dwell_d = '0;
      case (state_q)
        ROW0: begin
          keys_d[4:0] = ~col_s2_q;
          state_d     = ROW1;
        end
        ROW1: begin
          keys_d[9:5] = ~col_s2_q;
          state_d     = ROW2;
        end
        ROW2: begin
          keys_d[14:10] = ~col_s2_q;
          state_d       = ROW3;
        end
        ROW3: begin
          keys_d[18:15] = ~col_s2_q[3:0];
          state_d       = ROW0;
          eval_d        = 1'b1;
        end
        default: state_d = ROW0;
      endcase
    end else begin
      dwell_d = dwell_q + DWELL_W'(1);
    end

    row_n_d = ~(4'b0001 << state_d);

    // Code-key census; the OR of codes is only meaningful when exactly one is held.
    for (int unsigned i = 0; i < NCODE; i++) begin
      if (keys_q[5'(i)]) begin
        code_multi = code_multi | code_any;
        code_any   = 1'b1;
        scan_code  = scan_code | KEY_CODE[5'(i)];
      end
    end

    if (eval_q) begin
      if (code_multi) begin
        scan_err_d = 1'b1;
      end else begin
        if (scan_code != cand_q) begin
          cand_d = scan_code;
          cnt_d  = CNT_W'(1);
        end else if (cnt_q != DB_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end

        if (cnt_d == DB_MAX) begin
          if (cand_d == '0) begin
            mkey_d = '0;
          end else if (mkey_q == '0) begin
            mkey_d = cand_d;
          end else if (mkey_q != cand_d) begin
            // Force a zero gap: drop MKEY and re-qualify the new code from scratch.
            mkey_d = '0;
            cnt_d  = '0;
          end
        end
      end

      if (keys_q[PRO_IDX] != pro_cand_q) begin
        pro_cand_d = keys_q[PRO_IDX];
        pro_cnt_d  = CNT_W'(1);
      end else if (pro_cnt_q != DB_MAX) begin
        pro_cnt_d = pro_cnt_q + CNT_W'(1);
      end
      if (pro_cnt_d == DB_MAX) begin
        proceed_d = pro_cand_d;
      end
    end

`ifdef KEYPAD_STRB_EN
    key_strb_d = (mkey_d != '0) && (mkey_d != mkey_q);
`endif
  end

  // State and output registers.
  always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
    if (!SIM_RST_n) begin
      state_q    <= ROW0;
      row_n_q    <= 4'b1110;
      dwell_q    <= '0;
      col_s1_q   <= '1;  // idle columns (no key)
      col_s2_q   <= '1;
      keys_q     <= '0;
      eval_q     <= 1'b0;
      cand_q     <= '0;
      cnt_q      <= '0;
      mkey_q     <= '0;
      pro_cand_q <= 1'b0;
      pro_cnt_q  <= '0;
      proceed_q  <= 1'b0;
      scan_err_q <= 1'b0;
`ifdef KEYPAD_STRB_EN
      key_strb_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      row_n_q    <= row_n_d;
      dwell_q    <= dwell_d;
      col_s1_q   <= col_s1_d;
      col_s2_q   <= col_s2_d;
      keys_q     <= keys_d;
      eval_q     <= eval_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      mkey_q     <= mkey_d;
      pro_cand_q <= pro_cand_d;
      pro_cnt_q  <= pro_cnt_d;
      proceed_q  <= proceed_d;
      scan_err_q <= scan_err_d;
`ifdef KEYPAD_STRB_EN
      key_strb_q <= key_strb_d;
`endif
    end
  end

  assign kp.ROW_n    = row_n_q;
  assign kp.MKEY     = mkey_q;
  assign kp.PROCEED  = proceed_q;
  assign kp.SCAN_ERR = scan_err_q;
`ifdef KEYPAD_STRB_EN
  assign kp.KEY_STRB = key_strb_q;
`endif

endmodule
